// File: rtl/vga_anim_pkg.sv
// ----------------------------------------------------------------------------
// vga_anim_pkg
// Shared constants for the scroll animator: number of parallax layers, the
// default offset width and the fixed per-layer scroll-rate table (num/den,
// in pixels per animated frame).
// No ports; imported by the animator, its rate accumulators and its interface.
// ----------------------------------------------------------------------------
package vga_anim_pkg;

    localparam int N_LAYERS      = 5;
    localparam int OFF_W_DEFAULT = 10;

    // Layer 0 is the fastest (foreground) layer, layer 4 the slowest.
    localparam int NUM_X [N_LAYERS] = '{16, 7, 4, 2, 1};
    localparam int DEN_X [N_LAYERS] = '{ 1, 1, 1, 1, 2};
    localparam int NUM_Y [N_LAYERS] = '{ 2, 3, 1, 1, 1};
    localparam int DEN_Y [N_LAYERS] = '{ 1, 2, 2, 4, 6};

    // Width of a 0..den-1 phase counter; one bit minimum so den=1 still
    // gets a legal (constant-zero) register.
    function automatic int phase_width(input int den);
        return (den > 1) ? $clog2(den) : 1;
    endfunction

endpackage

// File: rtl/vga_scroll_animator_if.sv
// ----------------------------------------------------------------------------
// vga_scroll_animator_if
// Bundle of the animator's sync/control inputs and its frame/offset outputs.
//   master : the sync generator / control side (drives vsync_in, pause,
//            step, reverse; observes frame_tick, frame_count, offsets)
//   slave  : the animator side (the reverse direction)
// Parameter W: offset and frame counter width.
// ----------------------------------------------------------------------------
interface vga_scroll_animator_if
    import vga_anim_pkg::*;
#(
    parameter int W = OFF_W_DEFAULT
) (
    input logic clk
);

    logic         vsync_in;
    logic         pause;
    logic         step;
    logic         reverse;
    logic         frame_tick;
    logic [W-1:0] frame_count;
    logic [W-1:0] off_x [N_LAYERS];
    logic [W-1:0] off_y [N_LAYERS];

    modport master (
        input  clk,
        output vsync_in, pause, step, reverse,
        input  frame_tick, frame_count, off_x, off_y
    );

    modport slave (
        input  clk,
        input  vsync_in, pause, step, reverse,
        output frame_tick, frame_count, off_x, off_y
    );

endinterface

// File: rtl/vga_rate_accum.sv
// ----------------------------------------------------------------------------
// vga_rate_accum
// One scroll axis moving at NUM/DEN pixels per animated frame. A phase
// counter runs 0..DEN-1 on each advance; on the advance where it wraps,
// the offset moves by NUM (added, or subtracted when sub=1), modulo 2^W.
// Ports:
//   clk, rst_n : pixel clock, synchronous active-low reset
//   advance    : one-cycle frame advance strobe
//   sub        : subtract instead of add on this update
//   offset     : W-bit scroll offset
// ----------------------------------------------------------------------------
module vga_rate_accum
    import vga_anim_pkg::*;
#(
    parameter int NUM = 1,
    parameter int DEN = 1,
    parameter int W   = OFF_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    input  logic         sub,
    output logic [W-1:0] offset
);

    localparam int              PH_W    = phase_width(DEN);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEN - 1);
    localparam logic [W-1:0]    STEP    = W'(NUM);

    logic [PH_W-1:0] phase;
    logic            wrap;

    // With DEN=1 the phase register is stuck at 0, so every advance wraps.
    assign wrap = (phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= '0;
            offset <= '0;
        end else if (advance) begin
            phase <= wrap ? '0 : phase + 1'b1;
            if (wrap) begin
                offset <= sub ? offset - STEP : offset + STEP;
            end
        end
    end

endmodule

// File: rtl/vga_scroll_animator.sv
// ----------------------------------------------------------------------------
// vga_scroll_animator
// Advances a parallax scroll animation once per vsync rising edge. Ten
// vga_rate_accum instances (X and Y for 5 layers) hold the per-layer offsets.
// pause freezes the animation; a step pulse while paused is remembered and
// releases exactly one frame at the next vsync rise.
// Ports:
//   clk, rst_n       : pixel clock, synchronous active-low reset
//   vsync_in         : vertical sync, active high, clk-synchronous
//   pause            : level, freeze animation
//   step             : pulse, request one frame while paused
//   reverse          : level, scroll backwards (only with the option below)
//   frame_tick       : one-cycle pulse, cycle after an advancing vsync rise
//   frame_count      : advanced frames, modulo 2^OFF_W
//   off_x0..off_x4,
//   off_y0..off_y4   : per-layer scroll offsets
// Build option: define VGA_ANIM_REVERSE_EN to let reverse=1 subtract. Without
// it, reverse is accepted but has no effect.
// ----------------------------------------------------------------------------
module vga_scroll_animator
    import vga_anim_pkg::*;
#(
    parameter int OFF_W = OFF_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_in,
    input  logic             pause,
    input  logic             step,
    input  logic             reverse,
    output logic             frame_tick,
    output logic [OFF_W-1:0] frame_count,
    output logic [OFF_W-1:0] off_x0,
    output logic [OFF_W-1:0] off_x1,
    output logic [OFF_W-1:0] off_x2,
    output logic [OFF_W-1:0] off_x3,
    output logic [OFF_W-1:0] off_x4,
    output logic [OFF_W-1:0] off_y0,
    output logic [OFF_W-1:0] off_y1,
    output logic [OFF_W-1:0] off_y2,
    output logic [OFF_W-1:0] off_y3,
    output logic [OFF_W-1:0] off_y4
);

`ifdef VGA_ANIM_REVERSE_EN
    localparam logic REV_EN = 1'b1;
`else
    localparam logic REV_EN = 1'b0;
`endif

    logic             vs_q;
    logic             step_pending;
    logic             rise;
    logic             advance;
    logic             sub;
    logic [OFF_W-1:0] off_x [N_LAYERS];
    logic [OFF_W-1:0] off_y [N_LAYERS];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rise    = 1'b0;
        advance = 1'b0;
        sub     = 1'b0;
        rise    = vsync_in & ~vs_q;
        advance = rise & (~pause | step_pending | step);
        sub     = reverse & REV_EN;
    end

    // vs_q keeps tracking vsync_in through reset, so a vsync that is already
    // high when reset releases is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        vs_q <= vsync_in;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_tick   <= 1'b0;
            frame_count  <= '0;
            step_pending <= 1'b0;
        end else begin
            frame_tick <= advance;
            if (advance) begin
                frame_count  <= frame_count + 1'b1;
                step_pending <= 1'b0;   // a step seen with this rise is consumed here
            end else if (step) begin
                step_pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
        vga_rate_accum #(
            .NUM (NUM_X[i]),
            .DEN (DEN_X[i]),
            .W   (OFF_W)
        ) u_x (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .sub     (sub),
            .offset  (off_x[i])
        );

        vga_rate_accum #(
            .NUM (NUM_Y[i]),
            .DEN (DEN_Y[i]),
            .W   (OFF_W)
        ) u_y (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .sub     (sub),
            .offset  (off_y[i])
        );
    end

    assign off_x0 = off_x[0];
    assign off_x1 = off_x[1];
    assign off_x2 = off_x[2];
    assign off_x3 = off_x[3];
    assign off_x4 = off_x[4];
    assign off_y0 = off_y[0];
    assign off_y1 = off_y[1];
    assign off_y2 = off_y[2];
    assign off_y3 = off_y[3];
    assign off_y4 = off_y[4];

endmodule

// File: tb/tb_vga_scroll_animator.sv
// ----------------------------------------------------------------------------
// tb_vga_scroll_animator
// Self-checking bench for vga_scroll_animator. The reference model keeps the
// list of advanced frames (with their direction) and derives every expected
// offset arithmetically from the rate table: an axis with rate num/den moves
// by num on every den-th advance.
// ----------------------------------------------------------------------------
module tb_vga_scroll_animator;

    localparam int W  = 10;
    localparam int NL = 5;

    // Rate table, written out independently of the design package.
    localparam int TNX [NL] = '{16, 7, 4, 2, 1};
    localparam int TDX [NL] = '{ 1, 1, 1, 1, 2};
    localparam int TNY [NL] = '{ 2, 3, 1, 1, 1};
    localparam int TDY [NL] = '{ 1, 2, 2, 4, 6};

`ifdef VGA_ANIM_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_scroll_animator_if #(.W(W)) vif (.clk(clk));

    vga_scroll_animator #(.OFF_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_in    (vif.vsync_in),
        .pause       (vif.pause),
        .step        (vif.step),
        .reverse     (vif.reverse),
        .frame_tick  (vif.frame_tick),
        .frame_count (vif.frame_count),
        .off_x0      (vif.off_x[0]),
        .off_x1      (vif.off_x[1]),
        .off_x2      (vif.off_x[2]),
        .off_x3      (vif.off_x[3]),
        .off_x4      (vif.off_x[4]),
        .off_y0      (vif.off_y[0]),
        .off_y1      (vif.off_y[1]),
        .off_y2      (vif.off_y[2]),
        .off_y3      (vif.off_y[3]),
        .off_y4      (vif.off_y[4])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_vs;          // last sampled vsync level
    bit m_pend;        // remembered step request
    bit m_tick;        // expected frame_tick after the latest edge
    bit m_dirs [$];    // one entry per advanced frame: 1 = backwards
    int obs_ticks = 0; // frame_tick pulses seen on the DUT

    function automatic logic [W-1:0] m_off(input int num, input int den);
        int acc = 0;
        for (int k = 1; k <= m_dirs.size(); k++) begin
            if (k % den == 0) acc += m_dirs[k-1] ? -num : num;
        end
        return acc[W-1:0];
    endfunction

    function automatic logic [W-1:0] m_fc();
        int n = m_dirs.size();
        return n[W-1:0];
    endfunction

    // One clock: drive at the falling edge, update the model at the rising
    // edge, observe the DUT 1 time unit later.
    task automatic cyc(input bit r, input bit vs);
        bit rise, adv;
        @(negedge clk);
        rst_n        = r;
        vif.vsync_in = vs;
        @(posedge clk);
        if (!r) begin
            m_vs   = vs;
            m_pend = 1'b0;
            m_tick = 1'b0;
            m_dirs.delete();
        end else begin
            rise = vs && !m_vs;
            adv  = rise && (!vif.pause || m_pend || vif.step);
            m_vs = vs;
            if (adv) begin
                m_dirs.push_back(REV_EN && vif.reverse);
                m_pend = 1'b0;
            end else if (vif.step) begin
                m_pend = 1'b1;
            end
            m_tick = adv;
        end
        #1;
        if (vif.frame_tick === 1'b1) obs_ticks++;
    endtask

    task automatic rise_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(vif.off_x[i]), 32'(m_off(TNX[i], TDX[i])));
            check($sformatf("%s_y%0d", tag, i), 32'(vif.off_y[i]), 32'(m_off(TNY[i], TDY[i])));
        end
        check({tag, "_fc"},   32'(vif.frame_count), 32'(m_fc()));
        check({tag, "_tick"}, 32'(vif.frame_tick),  32'(m_tick));
    endtask

    task automatic do_reset(input bit vs);
        for (int i = 0; i < 3; i++) cyc(1'b0, vs);
    endtask

    int t0;

    initial begin
        vif.vsync_in = 1'b0;
        vif.pause    = 1'b0;
        vif.step     = 1'b0;
        vif.reverse  = 1'b0;

`ifdef VGA_ANIM_REVERSE_EN
        // Backwards from reset: one frame.
        vif.reverse = 1'b1;
        do_reset(1'b0);
        rise_n(1);
        check("rev_x0", 32'(vif.off_x[0]), 32'd1008);
        check("rev_x1", 32'(vif.off_x[1]), 32'd1017);
        check("rev_y0", 32'(vif.off_y[0]), 32'd1022);
        check_all("rev");
        vif.reverse = 1'b0;
`endif

        // Reset state, then three frames.
        do_reset(1'b0);
        check_all("rst");
        t0 = obs_ticks;
        rise_n(3);
        check("f3_fc",    32'(vif.frame_count), 32'd3);
        check("f3_x0",    32'(vif.off_x[0]), 32'd48);
        check("f3_x1",    32'(vif.off_x[1]), 32'd21);
        check("f3_x4",    32'(vif.off_x[4]), 32'd1);
        check("f3_y1",    32'(vif.off_y[1]), 32'd3);
        check("f3_y4",    32'(vif.off_y[4]), 32'd0);
        check("f3_ticks", 32'(obs_ticks - t0), 32'd3);
        check_all("f3");

        // Six frames total.
        rise_n(3);
        check("f6_y4", 32'(vif.off_y[4]), 32'd1);
        check("f6_y3", 32'(vif.off_y[3]), 32'd1);
        check("f6_y2", 32'(vif.off_y[2]), 32'd3);
        check("f6_y1", 32'(vif.off_y[1]), 32'd9);
        check_all("f6");

        // Paused: two frozen rises, a step between rises, two more rises.
        vif.pause = 1'b1;
        t0 = obs_ticks;
        rise_n(2);
        check("pz_fc", 32'(vif.frame_count), 32'd6);
        vif.step = 1'b1;
        cyc(1'b1, 1'b0);
        vif.step = 1'b0;
        rise_n(2);
        check("step_fc",    32'(vif.frame_count), 32'd7);
        check("step_ticks", 32'(obs_ticks - t0), 32'd1);
        check_all("step");
        vif.pause = 1'b0;

        // 64 frames: off_x0 wraps 1024 -> 0.
        do_reset(1'b0);
        rise_n(64);
        check("w64_x0", 32'(vif.off_x[0]), 32'd0);
        check("w64_fc", 32'(vif.frame_count), 32'd64);
        check_all("w64");

        // vsync high across reset release: no false edge.
        do_reset(1'b1);
        t0 = obs_ticks;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        check("vshi_ticks", 32'(obs_ticks - t0), 32'd0);
        check("vshi_fc",    32'(vif.frame_count), 32'd0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("vshi_edge", 32'(obs_ticks - t0), 32'd1);
        check_all("vshi");

        // Reset mid-run, coincident with a rise.
        rise_n(5);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("midrst_fc",   32'(vif.frame_count), 32'd0);
        check("midrst_tick", 32'(vif.frame_tick), 32'd0);
        check_all("midrst");

        // Randomized mix of vsync, pause, step, reverse and rare resets.
        for (int n = 0; n < 600; n++) begin
            vif.pause   = ($urandom_range(0, 3) == 0);
            vif.step    = ($urandom_range(0, 7) == 0);
            vif.reverse = $urandom_range(0, 1) == 1;
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0));
            check_all("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
